// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - MIDI message-type constants, state encodings and length decode
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  localparam logic [3:0] MSG_NOTE_OFF = 4'h8;
  localparam logic [3:0] MSG_NOTE_ON  = 4'h9;
  localparam logic [3:0] MSG_POLY_AT  = 4'hA;
  localparam logic [3:0] MSG_CC       = 4'hB;
  localparam logic [3:0] MSG_PROG     = 4'hC;
  localparam logic [3:0] MSG_CH_AT    = 4'hD;
  localparam logic [3:0] MSG_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_SEND
  } seq_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Total bytes including status; 0 marks a type this block will not send.
  function automatic logic [1:0] msg_len(input logic [3:0] msg_type);
    case (msg_type)
      MSG_NOTE_OFF, MSG_NOTE_ON, MSG_POLY_AT, MSG_CC, MSG_PITCH: msg_len = 2'd3;
      MSG_PROG, MSG_CH_AT:                                       msg_len = 2'd2;
      default:                                                   msg_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_byte_tx.sv
// rtl/midi_byte_tx.sv - single 8N1 byte serialiser, LSB first, registered line output
module midi_byte_tx
  import midi_pkg::*;
#(
  parameter int DIV = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (timer_q == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != TX_IDLE) timer_d = bit_end ? '0 : timer_q + TW'(1);
    case (state_q)
      TX_IDLE: if (load_i) begin
        state_d = TX_START;
        timer_d = '0;
        bit_d   = '0;
        shreg_d = byte_i;
      end
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA: if (bit_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = TX_STOP;
      end
      TX_STOP: if (bit_end) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level is computed from the current state and registered, so it trails the state by one clock.
  always_comb begin
    tx_d   = 1'b1;
    busy_o = (state_q != TX_IDLE);
    done_o = (state_q == TX_STOP) && bit_end;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/midi_out.sv
// rtl/midi_out.sv - MIDI channel-voice message transmitter with running status
module midi_out
  import midi_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = MIDI_BAUD,
  parameter int DIV            = CLK_FREQ / BAUD,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] CH_MESSAGE,
  input  logic [3:0] CHAN,
  input  logic [6:0] D1,
  input  logic [6:0] D2,
  output logic       ready,
  output logic       rej,
  output logic       MIDI_OUT
);

  seq_state_e  state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  d1_q, d1_d, d2_q, d2_d;
  logic [1:0]  idx_q, idx_d, last_idx_q, last_idx_d;
  logic [7:0]  last_status_q, last_status_d;
  logic        last_valid_q, last_valid_d;
  logic        rej_q, rej_d;
  logic [1:0]  len;
  logic        skip;
  logic        tx_load, tx_busy, tx_done;
  logic [7:0]  tx_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SEQ_IDLE;
      status_q      <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      last_status_q <= '0;
      last_valid_q  <= 1'b0;
      rej_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
      rej_q         <= rej_d;
    end
  end

  assign len  = msg_len(CH_MESSAGE);
  assign skip = (RUNNING_STATUS != 0) && last_valid_q && ({CH_MESSAGE, CHAN} == last_status_q);

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    rej_d         = 1'b0;
    case (state_q)
      SEQ_IDLE: if (start && ready) begin
        if (len == 2'd0) begin
          rej_d = 1'b1;
        end else begin
          status_d   = {CH_MESSAGE, CHAN};
          d1_d       = D1;
          d2_d       = D2;
          idx_d      = skip ? 2'd1 : 2'd0;
          last_idx_d = len - 2'd1;
          state_d    = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        state_d = SEQ_SEND;
        // Last status tracks what actually went onto the line, so it is latched as the status byte launches.
        if (idx_q == 2'd0) begin
          last_status_d = status_q;
          last_valid_d  = 1'b1;
        end
      end
      SEQ_SEND: if (tx_done) begin
        if (idx_q == last_idx_q) begin
          state_d = SEQ_IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SEQ_LOAD;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == SEQ_IDLE) && !tx_busy;
    tx_load = (state_q == SEQ_LOAD);
    case (idx_q)
      2'd0:    tx_byte = status_q;
      2'd1:    tx_byte = {1'b0, d1_q};
      default: tx_byte = {1'b0, d2_q};
    endcase
  end

  assign rej = rej_q;

  midi_byte_tx #(.DIV(DIV)) u_byte_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tx_load),
    .byte_i (tx_byte),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .tx_o   (MIDI_OUT)
  );

endmodule

// File: tb/tb_midi_out.sv
// tb/tb_midi_out.sv - table, corner-case and random checks of midi_out against a message-level model
module tb_midi_out;

  logic       clk, rst_n, start;
  logic [3:0] cm, chan;
  logic [6:0] d1, d2;
  logic       ready0, rej0, midi0;
  logic       ready1, rej1, midi1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rx_q0[$], rx_q1[$], exp_q0[$], exp_q1[$];
  logic       has_last;
  logic [7:0] last_st;
  logic       line_h[600];
  logic       rdy_h[600];

  typedef struct {
    logic [3:0]  cm;
    logic [3:0]  ch;
    logic [6:0]  d1;
    logic [6:0]  d2;
    logic        rej;
    int          n0;
    logic [23:0] b0;
    int          n1;
    logic [23:0] b1;
  } vec_t;

  vec_t tbl[11];

  midi_out #(.DIV(16), .RUNNING_STATUS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .CH_MESSAGE(cm), .CHAN(chan),
    .D1(d1), .D2(d2), .ready(ready0), .rej(rej0), .MIDI_OUT(midi0)
  );

  midi_out #(.DIV(16), .RUNNING_STATUS(0)) dut_nrs (
    .clk(clk), .rst_n(rst_n), .start(start), .CH_MESSAGE(cm), .CHAN(chan),
    .D1(d1), .D2(d2), .ready(ready1), .rej(rej1), .MIDI_OUT(midi1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic ln(input int w);
    return (w == 0) ? midi0 : midi1;
  endfunction

  // UART-style receiver: finds the falling edge, then samples mid-bit.
  task automatic rx_loop(input int w);
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (ln(w) === 1'b0) begin
        repeat (7) @(posedge clk);
        #1;
        if (ln(w) === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            #1;
            b[i] = ln(w);
          end
          repeat (16) @(posedge clk);
          #1;
          if (w == 0) rx_q0.push_back(b); else rx_q1.push_back(b);
        end
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_msg(input logic [3:0] m, input logic [3:0] c,
                                   input logic [6:0] a, input logic [6:0] b);
    int n;
    logic [7:0] st;
    case (m)
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 3;
      4'hC, 4'hD:                   n = 2;
      default:                      n = 0;
    endcase
    if (n == 0) return 0;
    st = {m, c};
    if (!(has_last && last_st == st)) exp_q0.push_back(st);
    has_last = 1'b1;
    last_st  = st;
    exp_q1.push_back(st);
    exp_q0.push_back({1'b0, a});
    exp_q1.push_back({1'b0, a});
    if (n == 3) begin
      exp_q0.push_back({1'b0, b});
      exp_q1.push_back({1'b0, b});
    end
    return n;
  endfunction

  task automatic send(input logic [3:0] m, input logic [3:0] c, input logic [6:0] a, input logic [6:0] b);
    @(negedge clk);
    cm = m; chan = c; d1 = a; d2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (ready0 && ready1) break;
      @(posedge clk);
      #1;
    end
    if (k == 3000) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_streams(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_len_rs"}, rx_q0.size(), exp_q0.size());
    for (int i = 0; i < exp_q0.size() && i < rx_q0.size(); i++) chk({tag, "_byte_rs"}, rx_q0[i], exp_q0[i]);
    chk({tag, "_len_nrs"}, rx_q1.size(), exp_q1.size());
    for (int i = 0; i < exp_q1.size() && i < rx_q1.size(); i++) chk({tag, "_byte_nrs"}, rx_q1[i], exp_q1[i]);
    rx_q0.delete(); rx_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    has_last = 1'b0;
  endtask

  initial begin
    logic [23:0] tmp;
    int fall, lw, g, k, n;
    logic [3:0] rm;

    tbl[0]  = '{4'h9, 4'h0, 7'd60,  7'd100, 1'b0, 3, 24'h903C64, 3, 24'h903C64};
    tbl[1]  = '{4'h9, 4'h0, 7'd62,  7'd0,   1'b0, 2, 24'h3E0000, 3, 24'h903E00};
    tbl[2]  = '{4'hB, 4'h0, 7'd16,  7'd64,  1'b0, 3, 24'hB01040, 3, 24'hB01040};
    tbl[3]  = '{4'hC, 4'h5, 7'd7,   7'd55,  1'b0, 2, 24'hC50700, 2, 24'hC50700};
    tbl[4]  = '{4'hC, 4'h5, 7'd9,   7'd0,   1'b0, 1, 24'h090000, 2, 24'hC50900};
    tbl[5]  = '{4'h3, 4'h0, 7'd1,   7'd2,   1'b1, 0, 24'h000000, 0, 24'h000000};
    tbl[6]  = '{4'hF, 4'h7, 7'd1,   7'd2,   1'b1, 0, 24'h000000, 0, 24'h000000};
    tbl[7]  = '{4'hD, 4'h5, 7'd100, 7'd0,   1'b0, 2, 24'hD56400, 2, 24'hD56400};
    tbl[8]  = '{4'hD, 4'h5, 7'd0,   7'd0,   1'b0, 1, 24'h000000, 2, 24'hD50000};
    tbl[9]  = '{4'hE, 4'hF, 7'd127, 7'd64,  1'b0, 3, 24'hEF7F40, 3, 24'hEF7F40};
    tbl[10] = '{4'h0, 4'h0, 7'd5,   7'd5,   1'b1, 0, 24'h000000, 0, 24'h000000};

    rst_n = 1'b0; start = 1'b0; cm = '0; chan = '0; d1 = '0; d2 = '0;
    has_last = 1'b0; last_st = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_line", midi0, 1'b1);
    chk("reset_ready", ready0, 1'b1);
    chk("reset_rej", rej0, 1'b0);
    chk("reset_ready_nrs", ready1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      send(tbl[v].cm, tbl[v].ch, tbl[v].d1, tbl[v].d2);
      chk("tbl_rej", rej0, tbl[v].rej);
      chk("tbl_rej_nrs", rej1, tbl[v].rej);
      chk("tbl_ready", ready0, tbl[v].rej);
      tmp = tbl[v].b0;
      for (int i = 0; i < tbl[v].n0; i++) exp_q0.push_back(tmp[23-8*i -: 8]);
      tmp = tbl[v].b1;
      for (int i = 0; i < tbl[v].n1; i++) exp_q1.push_back(tmp[23-8*i -: 8]);
      wait_idle("tbl");
      check_streams("tbl");
    end

    do_reset();

    // Frame timing, sampled once per clock relative to the accepting edge (k=0).
    send(4'h9, 4'h1, 7'd60, 7'd100);
    void'(model_msg(4'h9, 4'h1, 7'd60, 7'd100));
    line_h[0] = midi0; rdy_h[0] = ready0;
    for (int i = 1; i < 600; i++) begin
      @(posedge clk);
      #1;
      line_h[i] = midi0; rdy_h[i] = ready0;
    end
    fall = -1;
    for (int i = 0; i < 600; i++) if (line_h[i] == 1'b0 && fall < 0) fall = i;
    chk("first_fall", fall, 2);
    lw = 0;
    for (int i = (fall < 0 ? 0 : fall); i < 600 && line_h[i] == 1'b0; i++) lw++;
    chk("start_width", lw, 16);
    k = -1;
    for (int i = 0; i < 600; i++) if (rdy_h[i] == 1'b1 && k < 0) k = i;
    chk("ready_low", k, 483);
    g = 0;
    for (int i = 323; i >= 0 && line_h[i] == 1'b1; i--) g++;
    chk("interbyte_high", g, 17);
    chk("third_start", line_h[324], 1'b0);
    wait_idle("timing");
    check_streams("timing");

    // A start while busy must neither be queued nor rejected.
    send(4'h9, 4'h3, 7'd11, 7'd22);
    void'(model_msg(4'h9, 4'h3, 7'd11, 7'd22));
    repeat (100) @(posedge clk);
    send(4'hA, 4'h4, 7'd1, 7'd1);
    chk("busy_rej", rej0, 1'b0);
    chk("busy_ready", ready0, 1'b0);
    wait_idle("busy");
    check_streams("busy");

    send(4'h3, 4'h0, 7'd1, 7'd2);
    chk("rej_pulse", rej0, 1'b1);
    chk("rej_ready", ready0, 1'b1);
    chk("rej_line", midi0, 1'b1);
    @(posedge clk);
    #1;
    chk("rej_clear", rej0, 1'b0);
    chk("rej_ready2", ready0, 1'b1);
    chk("rej_line2", midi0, 1'b1);

    // Reset during data bit 3 of the second byte, then resend the same status.
    send(4'h9, 4'h2, 7'd64, 7'd32);
    void'(model_msg(4'h9, 4'h2, 7'd64, 7'd32));
    repeat (230) @(posedge clk);
    #1;
    chk("pre_reset_bit3", midi0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_line", midi0, 1'b1);
    chk("midreset_ready", ready0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    has_last = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rx_q0.delete(); rx_q1.delete(); exp_q0.delete(); exp_q1.delete();
    send(4'h9, 4'h2, 7'd64, 7'd32);
    void'(model_msg(4'h9, 4'h2, 7'd64, 7'd32));
    wait_idle("post_reset");
    check_streams("post_reset");

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) rm = 4'($urandom_range(0, 15));
      else rm = 4'($urandom_range(8, 14));
      cm = rm;
      chan = 4'($urandom_range(0, 1));
      d1 = 7'($urandom);
      d2 = 7'($urandom);
      send(rm, chan, d1, d2);
      n = model_msg(rm, chan, d1, d2);
      chk("rand_rej", rej0, (n == 0));
      chk("rand_rej_nrs", rej1, (n == 0));
      wait_idle("rand");
      check_streams("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_out.md
Name: midi_out

Overview:
- MIDI transmitter: serialises one channel-voice message per request onto a 31250-baud MIDI OUT line (8N1, LSB first, idle high).
- Transmit-side counterpart of midi_in; accepts the same message fields midi_in produces (CH_MESSAGE, CHAN, data bytes).
- Used for MIDI THRU/echo and for sending controller/pitch data from the synth to external gear.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 31250, line bit rate.
- DIV, CLK_FREQ/BAUD (1600), clock cycles per bit; benches override it to 16.
- RUNNING_STATUS, 1, when 1, omit the status byte if it equals the last status byte sent.

Ports:
- clk  in  1  system clock (clk50PLL domain).
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle request to send a message.
- CH_MESSAGE  in  4  status high nibble (0x8..0xE).
- CHAN  in  4  MIDI channel 0..15.
- D1  in  7  first data byte (note, controller number, program, pressure, or pitch LSB).
- D2  in  7  second data byte (velocity, controller value, or pitch MSB); ignored for 2-byte messages.
- ready  out  1  high when a start will be accepted.
- rej  out  1  one-cycle pulse when start carried an unsupported CH_MESSAGE.
- MIDI_OUT  out  1  serial line.

Behaviour:
- Reset (rst_n=0 at a clk edge): MIDI_OUT=1, ready=1, rej=0, FSM=IDLE, bit timer=0, stored last status cleared to "none".
- Reset mid-frame: the frame is truncated and MIDI_OUT is high from the next edge. No resume.
- Message length by CH_MESSAGE:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
  - 0xC, 0xD: 2 bytes.
  - 0x0..0x7 and 0xF: rejected. ready stays 1 and rej pulses in the cycle after start. Nothing is transmitted.
- Acceptance: start is sampled only when ready=1. On acceptance:
  - Capture status={CH_MESSAGE,CHAN}, {1'b0,D1} and {1'b0,D2}.
  - ready drops on the next edge.
  - start while ready=0 is ignored (no queueing, no rej).
- Running status: when RUNNING_STATUS=1 and the captured status equals the last status sent, transmit the data bytes only. The last status is updated when the status byte is sent.
- FSM states:
  - IDLE -> LOAD on an accepted start.
  - LOAD selects the next byte, then -> STARTBIT.
  - STARTBIT: MIDI_OUT=0 for DIV cycles, then -> DATA.
  - DATA: 8 bits, DIV cycles each, LSB first, then -> STOPBIT.
  - STOPBIT: MIDI_OUT=1 for DIV cycles. Then -> LOAD if bytes remain, else -> IDLE.
- Timing:
  - The start bit of the first byte appears on MIDI_OUT at the 2nd edge after the accepting edge (one LOAD cycle).
  - Each subsequent byte's start bit follows its predecessor's stop bit after one LOAD cycle, so the inter-byte gap is exactly 1 clock.
  - ready returns to 1 in the IDLE cycle after the last stop bit's DIV cycles.
- Bit timer: counts 0..DIV-1, width $clog2(DIV), wraps at DIV-1 and advances the bit. Bit counter is 3 bits.
- MIDI_OUT is registered (glitch-free). Data byte bit 7 is always 0, even if upstream logic drives garbage; D1 and D2 are only 7 bits wide.

Decomposition:
- Shared package midi_pkg:
  - Message-type constants MSG_NOTE_OFF=4'h8, MSG_NOTE_ON=4'h9, MSG_POLY_AT=4'hA, MSG_CC=4'hB, MSG_PROG=4'hC, MSG_CH_AT=4'hD, MSG_PITCH=4'hE.
  - Function msg_len(type) returning 0/2/3.
  - MIDI_BAUD=31250.
  - Also reused by midi_in users for decode compares.
- Sub-module midi_byte_tx: a single 8N1 byte serialiser (load/byte in, busy/done out, DIV parameter).
- midi_out keeps the message sequencer, running-status register and rej logic.

Test Plan (DIV=16, so one frame = 160 cycles):
- Note-on: CH_MESSAGE=9, CHAN=0, D1=60, D2=100 -> bytes 0x90, 0x3C, 0x64 decoded from MIDI_OUT. ready low for 3*160+3 cycles, then high.
- Program change: C, CHAN=5, D1=7 -> exactly 2 bytes 0xC5, 0x07. D2 not sent.
- Running status (RUNNING_STATUS=1):
  - Note-on ch0 60/100, then note-on ch0 62/0 -> second message is 0x3E, 0x00 only.
  - Then CC ch0 (B, D1=16, D2=64) -> 0xB0, 0x10, 0x40 with status resent.
  - With RUNNING_STATUS=0, all three messages carry a status byte.
- Busy/reject:
  - start asserted mid-frame -> ignored; the byte stream is unchanged.
  - CH_MESSAGE=3 while idle -> rej high exactly 1 cycle, MIDI_OUT stays 1, ready stays 1.
- Reset mid-operation: rst_n=0 during the DATA bit 3 of byte 2 -> MIDI_OUT=1 and ready=1 next edge. The following same-status note-on sends its status byte again (last status cleared).
- Bit timing: measure the start-bit low width = 16 cycles and the gap from the acceptance edge to the falling edge = 2 edges. The stop-to-next-start gap = 16+1 cycles high.
